// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (I) and data (D) ports.
// Optional I-port starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int XLEN      = 32,
    parameter int MAX_DEFER = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_i,
    input  logic [XLEN-1:0] i_addr_i,
    output logic [XLEN-1:0] i_rdata_o,
    output logic            i_done_o,
    output logic            i_stall_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [3:0]      d_wmask_i,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            d_done_o,
    output logic            d_stall_o,
    output logic            m_req_o,
    output logic            m_we_o,
    output logic [XLEN-1:0] m_addr_o,
    output logic [XLEN-1:0] m_wdata_o,
    output logic [3:0]      m_wmask_o,
    input  logic            m_ready_i,
    input  logic            m_rvalid_i,
    input  logic [XLEN-1:0] m_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_e          state_q;
    logic            owner_q;
    logic            m_req_q;
    logic            m_we_q;
    logic [XLEN-1:0] m_addr_q;
    logic [XLEN-1:0] m_wdata_q;
    logic [3:0]      m_wmask_q;
    logic            i_done_q;
    logic            d_done_q;
    logic [XLEN-1:0] i_rdata_q;
    logic [XLEN-1:0] d_rdata_q;
    logic            pick_i;
    logic            pick_d;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] MAX_DEFER_C = 4'(MAX_DEFER);
    logic [3:0] defer_cnt_q;
    logic [3:0] defer_cnt_d;

    // IDLE arbitration: D wins unless I has been deferred MAX_DEFER times in a row
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (i_req_i && (defer_cnt_q == MAX_DEFER_C)) begin
            pick_i = 1'b1;
        end else if (d_req_i) begin
            pick_d = 1'b1;
        end else if (i_req_i) begin
            pick_i = 1'b1;
        end else begin
            pick_i = 1'b0;
        end
    end

    // Defer count only moves on an IDLE-exit grant
    always_comb begin
        defer_cnt_d = defer_cnt_q;
        if (state_q == S_IDLE) begin
            if (pick_d && i_req_i) begin
                defer_cnt_d = (defer_cnt_q == 4'hF) ? defer_cnt_q : defer_cnt_q + 4'd1;
            end else if (pick_d || pick_i) begin
                defer_cnt_d = 4'd0;
            end else begin
                defer_cnt_d = defer_cnt_q;
            end
        end else begin
            defer_cnt_d = defer_cnt_q;
        end
    end

    // Starvation-guard counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            defer_cnt_q <= 4'd0;
        end else begin
            defer_cnt_q <= defer_cnt_d;
        end
    end
`else
    // IDLE arbitration: strict D priority
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (d_req_i) begin
            pick_d = 1'b1;
        end else if (i_req_i) begin
            pick_i = 1'b1;
        end else begin
            pick_i = 1'b0;
        end
    end
`endif

    // Transaction sequencer with registered memory-side and port-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWNER_D;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= {XLEN{1'b0}};
            m_wdata_q <= {XLEN{1'b0}};
            m_wmask_q <= 4'b0000;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_rdata_q <= {XLEN{1'b0}};
            d_rdata_q <= {XLEN{1'b0}};
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_d) begin
                        owner_q   <= OWNER_D;
                        m_req_q   <= 1'b1;
                        m_we_q    <= d_we_i;
                        m_addr_q  <= d_addr_i;
                        m_wdata_q <= d_wdata_i;
                        m_wmask_q <= d_wmask_i;
                        state_q   <= S_REQ;
                    end else if (pick_i) begin
                        owner_q   <= OWNER_I;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= i_addr_i;
                        m_wdata_q <= {XLEN{1'b0}};
                        m_wmask_q <= 4'b0000;
                        state_q   <= S_REQ;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (m_ready_i) begin
                        m_req_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    // Store acks also load d_rdata; the consumer ignores it for stores
                    if (m_rvalid_i) begin
                        if (owner_q == OWNER_D) begin
                            d_rdata_q <= m_rdata_i;
                            d_done_q  <= 1'b1;
                        end else begin
                            i_rdata_q <= m_rdata_i;
                            i_done_q  <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m_req_o   = m_req_q;
    assign m_we_o    = m_we_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign m_wmask_o = m_wmask_q;
    assign i_done_o  = i_done_q;
    assign d_done_o  = d_done_q;
    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
    assign i_stall_o = i_req_i & ~i_done_q;
    assign d_stall_o = d_req_i & ~d_done_q;

endmodule
